// File: rtl/memory_arbiter_if.sv
// Bus bundle between the fetch port, the load/store port, the arbiter and the shared data memory.
// The master side is the environment (requesters plus memory); the slave side is the arbiter.
interface memory_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_address;
  logic              if_ack;
  logic [DATA_W-1:0] if_read_data;

  logic              dm_req;
  logic              dm_write;
  logic [ADDR_W-1:0] dm_address;
  logic [DATA_W-1:0] dm_write_data;
  logic [3:0]        dm_byte_enable;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_read_data;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic [3:0]        mem_write_enable;
  logic [DATA_W-1:0] mem_read_data;

  modport master (
    output if_req, if_address,
    input  if_ack, if_read_data,
    output dm_req, dm_write, dm_address, dm_write_data, dm_byte_enable,
    input  dm_ack, dm_read_data,
    input  mem_address, mem_write_data, mem_write_enable,
    output mem_read_data
  );

  modport slave (
    input  if_req, if_address,
    output if_ack, if_read_data,
    input  dm_req, dm_write, dm_address, dm_write_data, dm_byte_enable,
    output dm_ack, dm_read_data,
    output mem_address, mem_write_data, mem_write_enable,
    input  mem_read_data
  );
endinterface

// File: rtl/memory_arbiter.sv
// Shares one single-port, registered-read data memory between instruction fetch and load/store,
// alternating on conflicts and emulating byte stores with a read-modify-write.
module memory_arbiter (
  input  logic             clk,
  input  logic             reset,
  memory_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACK, RMW_WRITE, RMW_ACK} state_t;
  typedef enum logic {FETCH, DATA} port_t;

  state_t     state, state_next;
  // last_grant doubles as the port currently being served: it only changes on a new grant.
  port_t      last_grant;
  logic       lat_write;
  logic [3:0] lat_be;
  logic       grant_fetch, grant_data;

  always_comb begin
    grant_data  = (state == IDLE) && !reset && bus.dm_req &&
                  (!bus.if_req || last_grant == FETCH);
    grant_fetch = (state == IDLE) && !reset && bus.if_req && !grant_data;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    state_next           = state;
    bus.mem_address      = '0;
    bus.mem_write_data   = '0;
    bus.mem_write_enable = 4'b0000;
    bus.if_ack           = 1'b0;
    bus.if_read_data     = '0;
    bus.dm_ack           = 1'b0;
    bus.dm_read_data     = '0;

    case (state)
      IDLE: begin
        if (grant_fetch) begin
          bus.mem_address = bus.if_address;
          state_next      = ACK;
        end else if (grant_data) begin
          bus.mem_address = bus.dm_address;
          if (bus.dm_write && bus.dm_byte_enable == 4'b1111) begin
            bus.mem_write_data   = bus.dm_write_data;
            bus.mem_write_enable = 4'b1111;
            state_next           = ACK;
          end else if (bus.dm_write && bus.dm_byte_enable != 4'b0000) begin
            state_next = RMW_WRITE;   // this cycle is the read phase
          end else begin
            state_next = ACK;
          end
        end
      end

      ACK: begin
        if (last_grant == FETCH) begin
          bus.if_ack       = 1'b1;
          bus.if_read_data = bus.mem_read_data;
        end else begin
          bus.dm_ack = 1'b1;
          if (!lat_write) bus.dm_read_data = bus.mem_read_data;
        end
        state_next = IDLE;
      end

      RMW_WRITE: begin
        bus.mem_address = bus.dm_address;
        // Merge the store lanes over the word read back during the grant cycle.
        for (int i = 0; i < 4; i++) begin
          bus.mem_write_data[8*i +: 8] = lat_be[i] ? bus.dm_write_data[8*i +: 8]
                                                   : bus.mem_read_data[8*i +: 8];
        end
        bus.mem_write_enable = 4'b1111;
        state_next           = RMW_ACK;
      end

      RMW_ACK: begin
        bus.dm_ack = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase

    // Reset wins in every state: no write reaches memory and no ack escapes.
    if (reset) begin
      bus.mem_write_enable = 4'b0000;
      bus.if_ack           = 1'b0;
      bus.dm_ack           = 1'b0;
      bus.if_read_data     = '0;
      bus.dm_read_data     = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state      <= IDLE;
      last_grant <= FETCH;
      lat_write  <= 1'b0;
      lat_be     <= 4'b0000;
    end else begin
      state <= state_next;
      if (grant_fetch) begin
        last_grant <= FETCH;
      end else if (grant_data) begin
        last_grant <= DATA;
        lat_write  <= bus.dm_write;
        lat_be     <= bus.dm_byte_enable;
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: a behavioural registered-read memory, a vector table
// of single accesses with an ack scoreboard, and hand-written conflict and reset-mid-RMW sequences.
module tb_memory_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  memory_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  memory_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Behavioural memory: full-word write whenever any enable bit is set, one-cycle registered read.
  logic [31:0] mem [logic [31:0]];
  always @(posedge clk) begin
    bus.mem_read_data <= mem.exists(bus.mem_address) ? mem[bus.mem_address] : 32'h0;
    if (bus.mem_write_enable != 4'b0000) mem[bus.mem_address] = bus.mem_write_data;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  typedef struct {
    logic        is_data;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  // Scoreboard: every ack pops the oldest expected completion.
  always @(negedge clk) begin
    if (bus.if_ack || bus.dm_ack) begin
      check("ack_exclusive", 32'(bus.if_ack & bus.dm_ack), 32'h0);
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_port", 32'(bus.dm_ack), 32'(e.is_data));
        check("read_data", bus.dm_ack ? bus.dm_read_data : bus.if_read_data, e.rdata);
        check("other_rdata_zero", bus.dm_ack ? bus.if_read_data : bus.dm_read_data, 32'h0);
      end
    end
  end

  typedef struct {
    logic        is_data;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    int          exp_lat;
    logic [31:0] exp_wword;
  } vec_t;

  task automatic apply(input vec_t v);
    int         lat;
    logic [3:0] we_or;
    @(posedge clk); #1;
    if (v.is_data) begin
      bus.dm_req         = 1'b1;
      bus.dm_write       = v.write;
      bus.dm_address     = v.addr;
      bus.dm_write_data  = v.wdata;
      bus.dm_byte_enable = v.be;
    end else begin
      bus.if_req     = 1'b1;
      bus.if_address = v.addr;
    end
    sb.push_back('{v.is_data, v.exp_rdata});
    lat   = -1;
    we_or = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      we_or |= bus.mem_write_enable;
      if (v.write && v.be != 4'b0000 && k == v.exp_lat - 1) begin
        check("write_enable", 32'(bus.mem_write_enable), 32'hF);
        check("write_word", bus.mem_write_data, v.exp_wword);
      end
      if (bus.if_ack || bus.dm_ack) begin
        lat = k;
        break;
      end
    end
    check("ack_latency", 32'(lat), 32'(v.exp_lat));
    if (!v.write || v.be == 4'b0000) check("no_write", 32'(we_or), 32'h0);
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
  endtask

  vec_t vecs[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset              = 1'b1;
    bus.if_req         = 1'b0;
    bus.if_address     = '0;
    bus.dm_req         = 1'b0;
    bus.dm_write       = 1'b0;
    bus.dm_address     = '0;
    bus.dm_write_data  = '0;
    bus.dm_byte_enable = '0;
    mem[32'h0]        = 32'h0;
    mem[32'h40]       = 32'hDEADBEEF;
    mem[32'h44]       = 32'h0;
    mem[32'h80]       = 32'h11223344;
    mem[32'hC0]       = 32'h55667788;
    mem[32'h10000000] = 32'h0;

    //            data  wr    addr           wdata         be       rdata         lat wword
    vecs[0]  = '{1'b0, 1'b0, 32'h40,       32'h0,        4'b0000, 32'hDEADBEEF, 1, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h80,       32'h0,        4'b0000, 32'h11223344, 1, 32'h0};
    vecs[2]  = '{1'b1, 1'b1, 32'h80,       32'h0000AA00, 4'b0010, 32'h0,        2, 32'h1122AA44};
    vecs[3]  = '{1'b1, 1'b0, 32'h80,       32'h0,        4'b0000, 32'h1122AA44, 1, 32'h0};
    vecs[4]  = '{1'b1, 1'b1, 32'h10000000, 32'h000003FF, 4'b1111, 32'h0,        1, 32'h000003FF};
    vecs[5]  = '{1'b1, 1'b1, 32'h10000000, 32'h00000001, 4'b0011, 32'h0,        2, 32'h00000001};
    vecs[6]  = '{1'b1, 1'b0, 32'h10000000, 32'h0,        4'b0000, 32'h00000001, 1, 32'h0};
    vecs[7]  = '{1'b1, 1'b1, 32'hC0,       32'hCAFEF00D, 4'b0000, 32'h0,        1, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 32'hC0,       32'h0,        4'b0000, 32'h55667788, 1, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 32'hC0,       32'hAB000000, 4'b1000, 32'h0,        2, 32'hAB667788};
    vecs[10] = '{1'b0, 1'b0, 32'hC0,       32'h0,        4'b0000, 32'hAB667788, 1, 32'h0};
    vecs[11] = '{1'b1, 1'b1, 32'h44,       32'h12345678, 4'b0101, 32'h0,        2, 32'h00340078};
    vecs[12] = '{1'b1, 1'b0, 32'h44,       32'h0,        4'b0000, 32'h00340078, 1, 32'h0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_if_ack", 32'(bus.if_ack), 32'h0);
    check("rst_dm_ack", 32'(bus.dm_ack), 32'h0);
    check("rst_mem_we", 32'(bus.mem_write_enable), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_mem_address", bus.mem_address, 32'h0);
    check("idle_mem_we", 32'(bus.mem_write_enable), 32'h0);
    check("idle_if_rdata", bus.if_read_data, 32'h0);
    check("idle_dm_rdata", bus.dm_read_data, 32'h0);

    foreach (vecs[i]) apply(vecs[i]);
    check("mem_80", mem[32'h80], 32'h1122AA44);
    check("mem_ledr", mem[32'h10000000], 32'h00000001);
    check("mem_c0", mem[32'hC0], 32'hAB667788);

    // Conflict alternation from reset: DATA, FETCH, DATA, FETCH with acks on cycles 1,3,5,7
    @(posedge clk); #1;
    reset          = 1'b1;
    bus.if_req     = 1'b1;
    bus.if_address = 32'h40;
    bus.dm_req     = 1'b1;
    bus.dm_write   = 1'b0;
    bus.dm_address = 32'h80;
    sb.push_back('{1'b1, 32'h1122AA44});
    sb.push_back('{1'b0, 32'hDEADBEEF});
    sb.push_back('{1'b1, 32'h1122AA44});
    sb.push_back('{1'b0, 32'hDEADBEEF});
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      logic [1:0] exp_acks;
      @(negedge clk);
      case (k)
        1, 5:    exp_acks = 2'b01;
        3, 7:    exp_acks = 2'b10;
        default: exp_acks = 2'b00;
      endcase
      check($sformatf("alt_acks_c%0d", k), 32'({bus.if_ack, bus.dm_ack}), 32'(exp_acks));
    end
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;

    // Reset during RMW_WRITE abandons the write and the ack
    @(posedge clk); #1;
    bus.dm_req         = 1'b1;
    bus.dm_write       = 1'b1;
    bus.dm_address     = 32'h40;
    bus.dm_write_data  = 32'h000000FF;
    bus.dm_byte_enable = 4'b0001;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rmw_rst_we", 32'(bus.mem_write_enable), 32'h0);
    check("rmw_rst_ack", 32'(bus.dm_ack), 32'h0);
    @(posedge clk); #1;
    reset      = 1'b0;
    bus.dm_req = 1'b0;
    @(negedge clk);
    check("post_rst_dm_ack", 32'(bus.dm_ack), 32'h0);
    check("post_rst_mem_address", bus.mem_address, 32'h0);
    check("post_rst_mem_we", 32'(bus.mem_write_enable), 32'h0);
    repeat (2) @(negedge clk);
    check("rmw_rst_mem_unchanged", mem[32'h40], 32'hDEADBEEF);
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shares the single-port, 1-cycle-registered-read data memory (`memory_map`, including the LEDR MMIO word) between the instruction-fetch port and the load/store port. The arbiter is a one-clock controller with a req/ack handshake per requester and fair alternation on conflicts. It emulates per-byte writes with a read-modify-write sequence, because the memory only performs full-word writes whenever any `write_enable` bit is set.

## Interface
- `ADDR_W`, 32: address width (`addr_t`).
- `DATA_W`, 32: data width (`data_t`); must be 32 (4 byte lanes).
- `clk` in 1: single clock; everything is rising-edge.
- `reset` in 1: synchronous, active-high.
- `if_req` in 1: fetch request; held until `if_ack`.
- `if_address` in 32: fetch address.
- `if_ack` out 1: one-cycle completion pulse.
- `if_read_data` out 32: fetched word; valid only while `if_ack`, else 0.
- `dm_req` in 1: data request; held until `dm_ack`.
- `dm_write` in 1: 1 = store, 0 = load.
- `dm_address` in 32: data address.
- `dm_write_data` in 32: store data, in lane-aligned position.
- `dm_byte_enable` in 4: store lanes; bit i = byte [8i+7:8i].
- `dm_ack` out 1: one-cycle completion pulse.
- `dm_read_data` out 32: load word; valid only while `dm_ack`, else 0.
- `mem_address` out 32: to memory `address`.
- `mem_write_data` out 32: to memory `write_data`.
- `mem_write_enable` out 4: to memory `write_enable`; only ever 4'b0000 or 4'b1111.
- `mem_read_data` in 32: from memory `read_data`, registered one cycle after the address.

## Operation
- **States:** IDLE, ACK, RMW_WRITE, RMW_ACK. Internal `last_grant` ∈ {FETCH, DATA}.
- **IDLE, no request:** `mem_address` = 0 and `mem_write_enable` = 0.
- **IDLE, arbitration:** a single requester is granted. If both request, the one ≠ `last_grant` is granted. `last_grant` updates on every grant.
- **Issue (IDLE, same cycle as the grant):** `mem_address` is driven combinationally from the granted port's address.
  - Fetch or load: `mem_write_enable` = 0; next state ACK.
  - Store with `dm_byte_enable` = 4'b1111: `mem_write_data` = `dm_write_data`, `mem_write_enable` = 4'b1111; next state ACK.
  - Store with `dm_byte_enable` = 4'b0000: no memory write; next state ACK (no-op completion).
  - Store with a partial mask: `mem_write_enable` = 0 (read phase); next state RMW_WRITE.
- **ACK:** assert the granted port's ack. For reads, its read_data = `mem_read_data`. Next state IDLE.
- **RMW_WRITE:** `mem_address` = the held `dm_address`. `mem_write_data` byte i = `dm_write_data` byte i if `dm_byte_enable[i]`, else `mem_read_data` byte i. `mem_write_enable` = 4'b1111. Next state RMW_ACK.
- **RMW_ACK:** `dm_ack` = 1, `dm_read_data` = 0. Next state IDLE.
- **Latched at grant:** the granted port, `dm_write`, and `dm_byte_enable`. Address and write data are sampled live, since requesters hold them until ack.
- **Request dropped before ack:** protocol violation. The access still completes and ack still pulses.
- **Addresses:** passed through unmodified; alignment and LEDR decode belong to memory. A partial store to LEDR is also read-modify-write.
- **Exclusivity:** `if_ack` and `dm_ack` are never high together.

## Timing
- **Reset values:** state IDLE, `last_grant` = FETCH (the first tie goes to DATA). Both acks 0, both read_data outputs 0, `mem_address` 0, `mem_write_enable` 0.
- **While `reset` is high:** `mem_write_enable` is forced to 0 and acks to 0 in every state. Reset in RMW_WRITE abandons the write (memory unchanged). Reset in ACK or RMW_ACK suppresses the ack.
- **Grant in cycle N:** read, full store, or empty-mask store acks in N+1. Partial store reads in N, writes in N+1, acks in N+2.
- **Back-to-back:** a new grant cannot occur in an ack cycle; the earliest next grant is the cycle after the ack. Peak throughput is one access per 2 cycles (3 for a partial store).
- **Request held through its own ack:** seen in IDLE as a new request.

## Test plan
- **Fetch:** reset, memory word 0x40 = 0xDEADBEEF; `if_req` addr 0x40 at cycle N → `if_ack` and `if_read_data` = 0xDEADBEEF at N+1; `dm_ack` 0 throughout.
- **Byte store:** word 0x80 = 0x11223344; store addr 0x80, data 0x0000AA00, be 4'b0010 → at N+1 `mem_write_data` = 0x1122AA44, `mem_write_enable` = 4'b1111; `dm_ack` at N+2; a following load returns 0x1122AA44.
- **Conflict alternation:** `if_req` and `dm_req` held together from reset → grants alternate DATA, FETCH, DATA, FETCH; acks at cycles 1, 3, 5, 7; never simultaneous.
- **LEDR:** full-word store 0x3FF to 0x10000000 → acks in 1 cycle, LEDR = 0x3FF; then half-word store 0x0000_0001 with be 4'b0011 → LEDR = 0x001 after RMW; load returns 0x00000001.
- **Empty mask and reset mid-RMW:** store be 4'b0000 → ack at N+1, `mem_write_enable` never nonzero. Partial store with `reset` high in its RMW_WRITE cycle → no write, no `dm_ack`, memory word unchanged; outputs at reset values the next cycle.
